// File: rtl/exp2_pkg.sv
// Shared definitions for the base-2 antilog datapath: widths, FSM states
// and the 2^(2^-i) constant table in unsigned Q1.23.
package exp2_pkg;

    localparam int FRAC_W = 15;
    localparam int GUARD  = 8;
    localparam int ACC_W  = 1 + FRAC_W + GUARD;
    localparam int IDX_W  = 5;
    localparam int N_W    = 4;
    localparam int OUT_W  = 16;
    localparam int SHL_W  = ACC_W + FRAC_W;

    localparam logic [IDX_W-1:0] IDX_FIRST = 5'd1;
    localparam logic [IDX_W-1:0] IDX_LAST  = 5'd15;
    localparam logic [ACC_W-1:0] ACC_ONE   = 24'h800000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        MUL  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // C[i] = round(2^(2^-i) * 2^(ACC_W-1)), i = 1..15
    function automatic logic [ACC_W-1:0] c_rom(input logic [IDX_W-1:0] i);
        case (i)
            5'd1:    c_rom = 24'hB504F3;
            5'd2:    c_rom = 24'h9837F0;
            5'd3:    c_rom = 24'h8B95C2;
            5'd4:    c_rom = 24'h85AAC3;
            5'd5:    c_rom = 24'h82CD87;
            5'd6:    c_rom = 24'h8164D2;
            5'd7:    c_rom = 24'h80B1ED;
            5'd8:    c_rom = 24'h8058D8;
            5'd9:    c_rom = 24'h802C64;
            5'd10:   c_rom = 24'h801630;
            5'd11:   c_rom = 24'h800B18;
            5'd12:   c_rom = 24'h80058C;
            5'd13:   c_rom = 24'h8002C6;
            5'd14:   c_rom = 24'h800163;
            5'd15:   c_rom = 24'h8000B1;
            default: c_rom = 24'h000000;
        endcase
    endfunction

endpackage

// File: rtl/exp2_antilog_16bit_if.sv
// Request/response bundle of the antilog block.
interface exp2_antilog_16bit_if;
    import exp2_pkg::*;

    logic              start_i;
    logic [N_W-1:0]    Ynguyen_i;
    logic [FRAC_W-1:0] Ythapphan_i;
    logic              busy_o;
    logic              fl_end;
    logic [OUT_W-1:0]  data_o;

    modport master (
        output start_i, Ynguyen_i, Ythapphan_i,
        input  busy_o, fl_end, data_o
    );

    modport slave (
        input  start_i, Ynguyen_i, Ythapphan_i,
        output busy_o, fl_end, data_o
    );
endinterface

// File: rtl/seq_mul_shift_add.sv
// Serial unsigned multiplier: one LSB-first shift-add step per cycle for
// W cycles. 'last' flags the final step and 'product' is the value the
// product register takes at the end of the current step, so the caller can
// capture the finished result on the same edge the last step completes.
module seq_mul_shift_add #(
    parameter int W = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [W-1:0]   mcand,
    input  logic [W-1:0]   mplier,
    output logic           last,
    output logic [2*W-1:0] product
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    logic [W-1:0]   mcand_r;
    logic [2*W-1:0] prod_r;
    logic [CNT_W-1:0] cnt_r;
    logic           run_r;
    logic [W:0]     sum_s;
    logic [2*W-1:0] step_s;

    // Add the multiplicand into the upper half when the current multiplier bit is set.
    always_comb begin
        sum_s = {1'b0, prod_r[2*W-1:W]};
        if (prod_r[0]) begin
            sum_s = {1'b0, prod_r[2*W-1:W]} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, prod_r[2*W-1:W]};
        end
        step_s = {sum_s, prod_r[W-1:1]};
    end

    assign last    = run_r && (cnt_r == CNT_LAST);
    assign product = step_s;

    // Load operands on request, then shift one multiplier bit per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_r <= {W{1'b0}};
            prod_r  <= {(2*W){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            run_r   <= 1'b0;
        end else if (load) begin
            mcand_r <= mcand;
            prod_r  <= {{W{1'b0}}, mplier};
            cnt_r   <= {CNT_W{1'b0}};
            run_r   <= 1'b1;
        end else if (run_r) begin
            prod_r <= step_s;
            cnt_r  <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_LAST) begin
                run_r <= 1'b0;
            end else begin
                run_r <= 1'b1;
            end
        end else begin
            prod_r <= prod_r;
        end
    end

endmodule

// File: rtl/exp2_antilog_16bit.sv
// Sequential base-2 antilog: data_o = floor(2^(n + f/2^15)) within +/-1.
// The accumulator starts at 1.0 and is multiplied by 2^(2^-i) for every set
// fraction bit; the integer part is applied as a final left shift. OUT spends
// two cycles so the done pulse lands 18 + 24*popcount(f) edges after capture.
module exp2_antilog_16bit
    import exp2_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    exp2_antilog_16bit_if.slave   bus
);

    state_t            state_r, state_nxt_s;
    logic [IDX_W-1:0]  idx_r, idx_nxt_s;
    logic [ACC_W-1:0]  acc_r, acc_nxt_s;
    logic [N_W-1:0]    n_r, n_nxt_s;
    logic [FRAC_W-1:0] f_r, f_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              fl_end_r, fl_end_nxt_s;
    logic [OUT_W-1:0]  data_r, data_nxt_s;
    logic              wait_r, wait_nxt_s;

    logic              mul_load_s;
    logic              mul_last_s;
    logic [2*ACC_W-1:0] mul_prod_s;
    logic [3:0]        bit_sel_s;
    logic              frac_bit_s;
    logic [SHL_W-1:0]  shl_s;
    logic              unused_bits_s;

    // Fraction bit with weight 2^-idx; only meaningful while idx <= 15.
    assign bit_sel_s  = 4'(IDX_LAST - idx_r);
    assign frac_bit_s = f_r[bit_sel_s];

    // Integer part applied as a left shift, then drop the Q1.23 fraction.
    assign shl_s = {{(SHL_W-ACC_W){1'b0}}, acc_r} << n_r;

    assign unused_bits_s = ^{mul_prod_s[2*ACC_W-1], mul_prod_s[ACC_W-2:0], shl_s[ACC_W-2:0]};

    seq_mul_shift_add #(.W(ACC_W)) u_mul (
        .clk     (clk_i),
        .rst     (rst_i),
        .load    (mul_load_s),
        .mcand   (acc_r),
        .mplier  (c_rom(idx_r)),
        .last    (mul_last_s),
        .product (mul_prod_s)
    );

    // Next-state and datapath update decisions.
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        acc_nxt_s    = acc_r;
        n_nxt_s      = n_r;
        f_nxt_s      = f_r;
        busy_nxt_s   = busy_r;
        fl_end_nxt_s = 1'b0;
        data_nxt_s   = data_r;
        wait_nxt_s   = wait_r;
        mul_load_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start_i) begin
                    n_nxt_s     = bus.Ynguyen_i;
                    f_nxt_s     = bus.Ythapphan_i;
                    acc_nxt_s   = ACC_ONE;
                    idx_nxt_s   = IDX_FIRST;
                    busy_nxt_s  = 1'b1;
                    wait_nxt_s  = 1'b0;
                    state_nxt_s = SCAN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (idx_r > IDX_LAST) begin
                    state_nxt_s = OUT;
                end else if (frac_bit_s) begin
                    mul_load_s  = 1'b1;
                    state_nxt_s = MUL;
                end else begin
                    idx_nxt_s   = idx_r + 5'd1;
                    state_nxt_s = SCAN;
                end
            end
            MUL: begin
                if (mul_last_s) begin
                    acc_nxt_s   = mul_prod_s[2*ACC_W-2:ACC_W-1];
                    idx_nxt_s   = idx_r + 5'd1;
                    state_nxt_s = SCAN;
                end else begin
                    state_nxt_s = MUL;
                end
            end
            OUT: begin
                if (wait_r) begin
                    data_nxt_s   = shl_s[SHL_W-1:ACC_W-1];
                    fl_end_nxt_s = 1'b1;
                    busy_nxt_s   = 1'b0;
                    wait_nxt_s   = 1'b0;
                    state_nxt_s  = IDLE;
                end else begin
                    wait_nxt_s   = 1'b1;
                    state_nxt_s  = OUT;
                end
            end
            default: begin
                busy_nxt_s  = 1'b0;
                wait_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= IDLE;
            idx_r    <= {IDX_W{1'b0}};
            acc_r    <= {ACC_W{1'b0}};
            n_r      <= {N_W{1'b0}};
            f_r      <= {FRAC_W{1'b0}};
            busy_r   <= 1'b0;
            fl_end_r <= 1'b0;
            data_r   <= {OUT_W{1'b0}};
            wait_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            idx_r    <= idx_nxt_s;
            acc_r    <= acc_nxt_s;
            n_r      <= n_nxt_s;
            f_r      <= f_nxt_s;
            busy_r   <= busy_nxt_s;
            fl_end_r <= fl_end_nxt_s;
            data_r   <= data_nxt_s;
            wait_r   <= wait_nxt_s;
        end
    end

    assign bus.busy_o = busy_r;
    assign bus.fl_end = fl_end_r;
    assign bus.data_o = data_r;

endmodule

// File: doc/exp2_antilog_16bit.md
Name: exp2_antilog_16bit

Overview:
- Sequential base-2 antilog: converts a fixed-point exponent (4-bit integer part, 15-bit fraction) to a 16-bit unsigned integer, floor(2^(Ynguyen + Ythapphan/2^15)).
- Inverse end of the log2 datapath. It consumes the same integer/fraction format that the log2 block produces.
- Each set fraction bit multiplies an accumulator by the constant 2^(2^-i) using a serial shift-add multiplier. The integer part is then applied as a final left shift.

Parameters:
- FRAC_W, 15, fraction bits of Ythapphan_i. Only 15 is supported because the constant table is sized for it.
- GUARD, 8, extra internal fraction bits that bound truncation error.
- ACC_W, 1+FRAC_W+GUARD (24), accumulator width in unsigned Q1.(FRAC_W+GUARD) format; also the number of multiplier cycles.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request. Sampled only in IDLE.
- Ynguyen_i  input  4  integer part n, range 0..15.
- Ythapphan_i  input  FRAC_W  fraction. MSB has weight 2^-1.
- busy_o  output  1  high from the capture edge until done.
- fl_end  output  1  one-cycle done pulse.
- data_o  output  16  result. Holds its value until the next completion.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy_o=0, fl_end=0, data_o=0; accumulator, index and bit counter cleared. Reset mid-operation aborts with no fl_end pulse.
- IDLE, start_i=1: latch n and f, set acc=1.0 (1<<(ACC_W-1)), idx=1, busy_o=1, go to SCAN. start_i while busy is ignored, not queued.
- SCAN, idx>FRAC_W: go to OUT.
- SCAN, f bit weight 2^-idx set: load multiplicand=acc and constant C[idx]; clear product and bit counter; go to MUL.
- SCAN, that bit clear: idx+=1, stay in SCAN.
- MUL: exactly ACC_W cycles, LSB-first shift-add of acc × C[idx]. Product is 2*ACC_W bits.
  - Last cycle: acc = product >> (ACC_W-1), truncated; idx+=1; return to SCAN.
- C[i] = round(2^(2^-i) × 2^(ACC_W-1)), i=1..15. All C[i] < 2^ACC_W.
- OUT: data_o = (acc << n) >> (ACC_W-1), truncated to 16 bits; fl_end=1 for one cycle; busy_o=0; go to IDLE.
  - acc < 2.0 and n ≤ 15, so the result is < 65536 and cannot overflow. No saturation logic.
- Latency: with k = popcount(f), fl_end is high 18+24k clock edges after the edge that sampled start_i. Minimum 18, maximum 378.
- Accuracy:
  - data_o is within ±1 of floor(2^(n+f)) for all inputs.
  - Exact when f=0: data_o = 1<<n.
- start_i=1 in the same cycle fl_end is high: the block is in IDLE after that edge, so start_i is sampled on the next cycle.

Decomposition:
- Package exp2_pkg:
  - FRAC_W, GUARD and ACC_W localparams.
  - State enum {IDLE, SCAN, MUL, OUT}.
  - 15-entry ACC_W-bit constant ROM C[1..15], precomputed hex.
- Sub-module seq_mul_shift_add#(ACC_W):
  - Serial unsigned multiplier with load/start, ACC_W-cycle run, done flag and 2*ACC_W product.
  - Same reset scheme as the top.
- The top keeps the FSM, idx counter, fraction bit select and output shifter.

Test Plan:
- n=0, f=0 -> data_o=1; fl_end exactly 18 cycles after start; busy_o high during the run.
- n=3 and n=15, f=0 -> data_o=8 and 32768.
- n=4, f=0x4000 (0.5) -> data_o=22 (true 22.627); latency 42.
- n=15, f=0x7FFF -> data_o in 65533..65535, no wrap; latency 378.
- Sweep n=0..15 with f random, compare against a real-math model (±1). Pulse start_i while busy -> ignored; data_o changes only at fl_end.
- Assert rst_i mid-MUL -> all outputs 0 immediately, no fl_end. A following start with n=1, f=0 -> data_o=2.
